if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue_pkg.sv | 18 +
 rtl/if_fetch_queue_fetch_fifo.sv | 51 +++++
 rtl/if_fetch_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch prefetch queue.
package if_fetch_queue_pkg;

  localparam int          INST_W        = 32;
  localparam logic [31:0] BUBBLE        = 32'h0000_0013;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Pointer-based circular buffer of {pc, inst} fetch entries with a flush input.
module fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [INST_W-1:0]        push_inst,
  input  logic                     pop,
  output logic [31:0]              head_pc,
  output logic [INST_W-1:0]        head_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{pc: push_pc, inst: push_inst};
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // The extra pointer bit makes the difference a full 0..DEPTH occupancy.
  assign count     = wr_ptr - rd_ptr;
  assign head_pc   = mem[rd_ptr[PW-1:0]].pc;
  assign head_inst = mem[rd_ptr[PW-1:0]].inst;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count == (PW+1)'(DEPTH)));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: credit-based issue, redirect/kill control and a prefetch queue.
// Optional macro IF_FETCH_BYPASS_EN presents a response directly when the queue is empty.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          kill_q;
  logic [CW-1:0] fifo_count;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;
  logic          fifo_empty;
  logic          issue;
  logic          accept;
  logic          bypass;
  logic          push;
  logic          pop;

  assign fifo_empty = (fifo_count == '0);

  // Credit: queued entries plus the one outstanding request must leave room for its response.
  assign issue = !reset && !redirect_valid &&
                 (({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(QUEUE_DEPTH));

  // A response is only ours if a live, unkilled request is waiting for it.
  assign accept = !reset && !redirect_valid && imem_rvalid && inflight_q && !kill_q;

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = accept && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !(bypass && id_ready);
  assign pop  = !reset && !redirect_valid && !fifo_empty && id_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= align_pc(redirect_target);
      // Any response still due after this cycle belongs to the old path.
      inflight_q <= inflight_q && !imem_rvalid;
      kill_q     <= inflight_q && !imem_rvalid;
    end else begin
      if (issue) begin
        pc_q     <= pc_q + PC_INC;
        req_pc_q <= pc_q;
      end
      inflight_q <= issue || (inflight_q && !imem_rvalid);
      if (imem_rvalid && inflight_q) kill_q <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_pc   (req_pc_q),
    .push_inst (imem_rdata),
    .pop       (pop),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (fifo_count)
  );

  // NOTE: every output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = BUBBLE;
    if (!reset) begin
      if (!fifo_empty) begin
        out_valid = 1'b1;
        out_pc    = head_pc;
        out_inst  = head_inst;
      end else if (bypass) begin
        out_valid = 1'b1;
        out_pc    = req_pc_q;
        out_inst  = imem_rdata;
      end
    end
  end

endmodule
